// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between a power-up config sequencer (req0) and a runtime
// control writer (req1): latch a winner, pulse exec, wait for done or timeout, respond.
module i2c_bus_arbiter #(
    parameter logic        PRIO_MODE   = 1'b0,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_req,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req0_rh_wl,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_req,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    input  logic       req1_rh_wl,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic       i2c_exec,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_data_w,
    output logic       i2c_rh_wl,
    input  logic [7:0] i2c_data_r,
    input  logic       i2c_done,
    output logic [1:0] grant,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        last_grant;
    logic        win;
    logic        any_req;
    logic        expire;
    logic        finish;
    logic [7:0]  rdata_v;

    assign any_req = req0_req | req1_req;
    assign expire  = (cnt == TIMEOUT_CYC - 16'd1);
    assign finish  = i2c_done | expire;
    // A timed-out transaction returns zero data; a real done always wins.
    assign rdata_v = i2c_done ? i2c_data_r : 8'h00;

    // Winner index: 0 = req0, 1 = req1.
    always_comb begin
        win = req1_req;
        if (req0_req && req1_req)
            win = PRIO_MODE ? 1'b0 : ~last_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 16'd0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            busy       <= 1'b0;
            i2c_exec   <= 1'b0;
            i2c_addr   <= 8'h00;
            i2c_data_w <= 8'h00;
            i2c_rh_wl  <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= 8'h00;
            req0_err   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= 8'h00;
            req1_err   <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            i2c_exec  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    grant      <= win ? 2'b10 : 2'b01;
                    i2c_addr   <= win ? req1_addr  : req0_addr;
                    i2c_data_w <= win ? req1_wdata : req0_wdata;
                    i2c_rh_wl  <= win ? req1_rh_wl : req0_rh_wl;
                end
                ISSUE: begin
                    i2c_exec <= 1'b1;
                    cnt      <= 16'd0;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (finish) begin
                        if (grant[1]) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= rdata_v;
                            req1_err   <= ~i2c_done;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= rdata_v;
                            req0_err   <= ~i2c_done;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant[1];
                    grant      <= 2'b00;
                    req0_rdata <= 8'h00;
                    req0_err   <= 1'b0;
                    req1_rdata <= 8'h00;
                    req1_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: two instances (round-robin / fixed-priority with short
// timeout) share stimulus; a scoreboard checks issues and responses of the selected one.
module tb_i2c_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_req = 0, req0_rh_wl = 0, req1_req = 0, req1_rh_wl = 0;
    logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic [7:0] i2c_data_r = 0;
    logic i2c_done = 0;

    logic [1:0]       exec_v, done0_v, done1_v, err0_v, err1_v, rhwl_v, busy_v;
    logic [1:0][7:0]  rd0_v, rd1_v, addr_v, dw_v;
    logic [1:0][1:0]  grant_v;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    typedef struct { logic [1:0] grant; logic [7:0] addr; logic [7:0] wdata; logic rh; } iss_t;
    typedef struct { logic id; logic [7:0] rdata; logic err; } resp_t;
    iss_t  iss_q[$];
    resp_t resp_q[$];
    iss_t  ie;
    resp_t re;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.PRIO_MODE(1'b0), .TIMEOUT_CYC(16'd128)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_req(req0_req), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rh_wl(req0_rh_wl),
        .req0_done(done0_v[0]), .req0_rdata(rd0_v[0]), .req0_err(err0_v[0]),
        .req1_req(req1_req), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rh_wl(req1_rh_wl),
        .req1_done(done1_v[0]), .req1_rdata(rd1_v[0]), .req1_err(err1_v[0]),
        .i2c_exec(exec_v[0]), .i2c_addr(addr_v[0]), .i2c_data_w(dw_v[0]), .i2c_rh_wl(rhwl_v[0]),
        .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .grant(grant_v[0]), .busy(busy_v[0]));

    i2c_bus_arbiter #(.PRIO_MODE(1'b1), .TIMEOUT_CYC(16'd16)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_req(req0_req), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rh_wl(req0_rh_wl),
        .req0_done(done0_v[1]), .req0_rdata(rd0_v[1]), .req0_err(err0_v[1]),
        .req1_req(req1_req), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rh_wl(req1_rh_wl),
        .req1_done(done1_v[1]), .req1_rdata(rd1_v[1]), .req1_err(err1_v[1]),
        .i2c_exec(exec_v[1]), .i2c_addr(addr_v[1]), .i2c_data_w(dw_v[1]), .i2c_rh_wl(rhwl_v[1]),
        .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .grant(grant_v[1]), .busy(busy_v[1]));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int s);
        return {exec_v[s], done0_v[s], done1_v[s], err0_v[s], err1_v[s], busy_v[s], rhwl_v[s],
                rd0_v[s], rd1_v[s], addr_v[s], dw_v[s], grant_v[s]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_req = 0; req1_req = 0; i2c_done = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_exec();
        int n = 0;
        while (!exec_v[sel] && n < 100) begin tick(); n++; end
        chk("exec_seen", exec_v[sel], 1);
    endtask

    task automatic serve(input int dly, input logic [7:0] data);
        repeat (dly) tick();
        i2c_done = 1'b1; i2c_data_r = data;
        tick();
        i2c_done = 1'b0;
    endtask

    // Scoreboard: issue and response events of the selected instance.
    always @(negedge clk) if (rst_n) begin
        if (exec_v[sel]) begin
            if (iss_q.size() == 0) chk("unexp_exec", 1, 0);
            else begin
                ie = iss_q.pop_front();
                chk("iss_grant", grant_v[sel], ie.grant);
                chk("iss_addr", addr_v[sel], ie.addr);
                chk("iss_wdata", dw_v[sel], ie.wdata);
                chk("iss_rhwl", rhwl_v[sel], ie.rh);
            end
        end
        if (done0_v[sel] || done1_v[sel]) begin
            if (resp_q.size() == 0) chk("unexp_done", 1, 0);
            else begin
                re = resp_q.pop_front();
                chk("resp_id", {done1_v[sel], done0_v[sel]}, re.id ? 2'b10 : 2'b01);
                chk("resp_rdata", re.id ? rd1_v[sel] : rd0_v[sel], re.rdata);
                chk("resp_err", re.id ? err1_v[sel] : err0_v[sel], re.err);
                chk("other_quiet", re.id ? {err0_v[sel], rd0_v[sel]} : {err1_v[sel], rd1_v[sel]}, 0);
            end
        end
    end

    initial begin
        int n;
        // Basic write on round-robin instance, with stray done after reset.
        sel = 0;
        do_reset();
        chk("reset_rr", outs(0), 0);
        chk("reset_fp", outs(1), 0);
        i2c_done = 1'b1; tick(); i2c_done = 1'b0; tick();
        chk("stray_done", {busy_v[0], done0_v[0], done1_v[0]}, 0);
        req0_req = 1; req0_addr = 8'h0E; req0_wdata = 8'h10; req0_rh_wl = 0;
        iss_q.push_back('{2'b01, 8'h0E, 8'h10, 1'b0});
        resp_q.push_back('{1'b0, 8'h00, 1'b0});
        tick();
        chk("lat1_exec", exec_v[0], 0);
        chk("lat1_grant", grant_v[0], 2'b01);
        tick();
        chk("lat2_exec", exec_v[0], 1);
        tick();
        chk("exec_1cyc", exec_v[0], 0);
        serve(97, 8'h00);
        chk("w_done", done0_v[0], 1);
        chk("w_err", err0_v[0], 0);
        req0_req = 0;
        tick();
        chk("w_idle", {busy_v[0], done0_v[0], grant_v[0]}, 0);

        // Read by req1.
        req1_req = 1; req1_addr = 8'h34; req1_wdata = 8'h77; req1_rh_wl = 1;
        iss_q.push_back('{2'b10, 8'h34, 8'h77, 1'b1});
        resp_q.push_back('{1'b1, 8'hA5, 1'b0});
        wait_exec();
        serve(20, 8'hA5);
        chk("r_done1", done1_v[0], 1);
        chk("r_done0", done0_v[0], 0);
        req1_req = 0;
        tick();

        // Round-robin with both held.
        do_reset();
        req0_addr = 8'h01; req0_wdata = 8'h11; req0_rh_wl = 0;
        req1_addr = 8'h02; req1_wdata = 8'h22; req1_rh_wl = 1;
        req0_req = 1; req1_req = 1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) iss_q.push_back('{2'b01, 8'h01, 8'h11, 1'b0});
            else            iss_q.push_back('{2'b10, 8'h02, 8'h22, 1'b1});
            resp_q.push_back('{(k % 2 == 1), 8'h40 + 8'(k), 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            wait_exec();
            serve(5, 8'h40 + 8'(k));
            chk("rr_done", {done1_v[0], done0_v[0]}, (k % 2) ? 2'b10 : 2'b01);
            if (k == 3) begin req0_req = 0; req1_req = 0; end
            tick();
        end

        // Fixed priority: req0 keeps winning.
        sel = 1;
        do_reset();
        req0_req = 1; req1_req = 1;
        for (int k = 0; k < 3; k++) begin
            iss_q.push_back('{2'b01, 8'h01, 8'h11, 1'b0});
            resp_q.push_back('{1'b0, 8'h50 + 8'(k), 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            wait_exec();
            serve(3, 8'h50 + 8'(k));
            chk("fp_done0", done0_v[1], 1);
            if (k == 2) begin req0_req = 0; req1_req = 0; end
            tick();
        end

        // Timeout (16 cycles), then a late done in IDLE.
        do_reset();
        req0_req = 1; req0_addr = 8'h55; req0_wdata = 8'h66; req0_rh_wl = 1;
        iss_q.push_back('{2'b01, 8'h55, 8'h66, 1'b1});
        resp_q.push_back('{1'b0, 8'h00, 1'b1});
        i2c_data_r = 8'hFF;
        wait_exec();
        n = 0;
        while (!done0_v[1] && n < 40) begin tick(); n++; end
        chk("to_latency", n, 16);
        chk("to_err", err0_v[1], 1);
        req0_req = 0;
        tick();
        i2c_done = 1'b1; tick(); i2c_done = 1'b0;
        tick(); tick();
        chk("late_done", {busy_v[1], done0_v[1], done1_v[1]}, 0);

        // Done coincides with final timeout cycle.
        req1_req = 1; req1_addr = 8'h66; req1_wdata = 8'h00; req1_rh_wl = 1;
        iss_q.push_back('{2'b10, 8'h66, 8'h00, 1'b1});
        resp_q.push_back('{1'b1, 8'h3C, 1'b0});
        wait_exec();
        serve(15, 8'h3C);
        chk("coin_done", done1_v[1], 1);
        chk("coin_err", err1_v[1], 0);
        req1_req = 0;
        tick();

        // Reset mid-WAIT, then normal service.
        sel = 0;
        do_reset();
        req0_req = 1; req0_addr = 8'h0A; req0_wdata = 8'h0B; req0_rh_wl = 0;
        iss_q.push_back('{2'b01, 8'h0A, 8'h0B, 1'b0});
        wait_exec();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(0), 0);
        req0_req = 0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst", outs(0), 0);
        req0_req = 1; req0_addr = 8'h0C; req0_wdata = 8'h0D;
        iss_q.push_back('{2'b01, 8'h0C, 8'h0D, 1'b0});
        resp_q.push_back('{1'b0, 8'h99, 1'b0});
        wait_exec();
        serve(10, 8'h99);
        chk("rst_recover", done0_v[0], 1);
        req0_req = 0;
        tick(); tick();

        chk("iss_q_empty", iss_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C master (i2c_dri) between two requesters: req0 is the power-up register configuration sequencer; req1 is the runtime control writer (volume, mute, reads).
- Runs on the I2C driver's operation clock (dri_clk).
- Latches one requester's transaction, issues a single exec pulse to the driver, and waits for completion or timeout.
- Returns per-requester done, read data and error.

Parameters:
- PRIO_MODE, 1'b0, arbitration policy: 0 = round-robin between req0/req1, 1 = fixed priority with req0 highest.
- TIMEOUT_CYC, 16'd50000, clk cycles to wait for i2c_done before aborting a transaction with an error.

Ports:
- clk  in  1  operation clock (driver dri_clk)
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req0_req  in  1  requester 0 request; held high with fields stable until req0_done
- req0_addr  in  8  requester 0 register address
- req0_wdata  in  8  requester 0 write data
- req0_rh_wl  in  1  requester 0 direction: 1 = read, 0 = write
- req0_done  out  1  one-cycle completion pulse to requester 0
- req0_rdata  out  8  read data, valid while req0_done=1
- req0_err  out  1  timeout flag, valid while req0_done=1
- req1_req, req1_addr, req1_wdata, req1_rh_wl, req1_done, req1_rdata, req1_err: same directions, widths and meanings for requester 1
- i2c_exec  out  1  one-cycle start pulse to driver
- i2c_addr  out  8  latched address to driver
- i2c_data_w  out  8  latched write data to driver
- i2c_rh_wl  out  1  latched direction to driver
- i2c_data_r  in  8  driver read data
- i2c_done  in  1  driver one-cycle completion pulse
- grant  out  2  one-hot owner of the bus (bit0 = req0); 0 when idle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM enters IDLE, timeout counter is 0, last_grant = 1 (so req0 wins the first tie).
  - Asserting reset mid-transaction aborts immediately with no done pulse.
  - A stray i2c_done after reset release is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any reqN_req is high, select the winner and latch its addr, wdata and rh_wl into the i2c_* outputs.
  - Set grant and go to ISSUE.
  - Round-robin tie: the requester not equal to last_grant wins.
  - Fixed priority tie: req0 wins.
  - A single requesting source always wins.
- ISSUE:
  - i2c_exec = 1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
  - Latency: i2c_exec is high 2 cycles after reqN_req is first seen high in IDLE.
- WAIT:
  - Counter increments each cycle.
  - If i2c_done = 1: capture i2c_data_r, set err = 0, go to RESP.
  - Else if counter == TIMEOUT_CYC-1: set rdata = 8'h00, err = 1, go to RESP.
  - If i2c_done and expiry coincide, i2c_done wins (err = 0).
- RESP:
  - The granted reqN_done = 1 for one cycle, with reqN_rdata and reqN_err valid.
  - Update last_grant to the served requester, clear grant, return to IDLE.
  - The non-granted requester's done, rdata and err stay 0.
- i2c_addr, i2c_data_w and i2c_rh_wl hold stable from ISSUE until the next grant.
- Requester inputs are sampled only in IDLE; changes during ISSUE, WAIT or RESP have no effect.
- i2c_done outside WAIT (including a late done after a timeout) is ignored.
- A requester must drop req in the cycle after its done. A req still high in IDLE is treated as a new request.
- No starvation in round-robin mode: with both requests held continuously, grants alternate 0, 1, 0, 1, and so on.

Test Plan:
- Reset, then req0 write (addr 8'h0E, data 8'h10) -> 2 cycles later i2c_exec pulses once with i2c_addr = 8'h0E, i2c_data_w = 8'h10, i2c_rh_wl = 0, grant = 2'b01. Model i2c_done after 100 cycles -> req0_done pulses 1 cycle later with req0_err = 0, then busy falls.
- req1 read (addr 8'h34), model returns i2c_data_r = 8'hA5 with i2c_done -> req1_done = 1, req1_rdata = 8'hA5, req1_err = 0; req0 outputs stay 0.
- PRIO_MODE = 0, both requesters held continuously for 4 transactions -> grant sequence 01, 10, 01, 10. PRIO_MODE = 1, same stimulus -> req0 served every time while its req is held.
- TIMEOUT_CYC = 16, i2c_done never asserted -> RESP reached 16 cycles after entering WAIT; req0_done = 1, req0_err = 1, req0_rdata = 8'h00. A late i2c_done injected in IDLE -> no done pulse.
- i2c_done coinciding with the final timeout cycle -> err = 0 and captured data returned.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously, no done pulse. After release, a new req0 is served normally.
